// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and its display helpers.
//   state_t        : timer control states
//   SEG_BLANK      : all segments off (active-low)
//   SEG_0..SEG_9   : active-low {a,b,c,d,e,f,g} patterns for decimal digits
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

endpackage

// File: rtl/bcd_to_ssd.sv
// Combinational BCD -> active-low seven-segment decoder.
//   bcd   : 4-bit digit (values above 9 show blank)
//   blank : force all segments off
//   seg   : {a,b,c,d,e,f,g}, bit6=a, active-low
module bcd_to_ssd
  import timer_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/countdown_ssd_timer.sv
// BCD countdown timer with multiplexed common-anode seven-segment output.
//   clk, reset          : clock, synchronous active-high reset
//   start/pause/load    : one-cycle control pulses (load > pause > start)
//   load_bcd            : packed BCD load value, nibbles >9 clamp to 9
//   count_bcd           : current count, MS digit in top nibble
//   running             : high while counting
//   expired             : one-cycle pulse when the count reaches zero
//   anode               : active-low digit enables, MSB = leftmost digit
//   ssdOut              : active-low segments {a..g} for the lit digit
module countdown_ssd_timer
  import timer_pkg::*;
#(
  parameter int                        NUM_DIGITS   = 4,
  parameter int                        TICK_DIV     = 100000000,
  parameter int                        DWELL_CYCLES = 524288,
  parameter logic [4*NUM_DIGITS-1:0]   START_BCD    = 16'h0099,
  parameter int                        LZ_BLANK     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_bcd,
  output logic [4*NUM_DIGITS-1:0]   count_bcd,
  output logic                      running,
  output logic                      expired,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [6:0]                ssdOut
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);

  state_t                          state, state_nx;
  logic [NUM_DIGITS-1:0][3:0]      cnt_q, cnt_dec, cnt_ld;
  logic [PW-1:0]                   presc;
  logic                            at_term, tick, dec_zero, borrow;

  assign count_bcd = cnt_q;
  assign running   = (state == ST_RUNNING);
  assign at_term   = (presc == PMAX);
  // A tick that coincides with load or pause is dropped; the prescaler
  // stays at terminal count so a resume ticks on its first running cycle.
  assign tick      = (state == ST_RUNNING) && !load && !pause && at_term;

  // Ripple-borrow BCD decrement across all digits in one cycle.
  always_comb begin
    borrow  = 1'b1;
    cnt_dec = cnt_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (borrow) begin
        if (cnt_q[d] == 4'd0) begin
          cnt_dec[d] = 4'd9;
        end else begin
          cnt_dec[d] = cnt_q[d] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  assign dec_zero = (cnt_dec == '0);

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_clamp
    assign cnt_ld[d] = (load_bcd[4*d +: 4] > 4'd9) ? 4'd9 : load_bcd[4*d +: 4];
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start && !pause && (cnt_q != '0)) state_nx = ST_RUNNING;
        ST_RUNNING: if (pause)                            state_nx = ST_IDLE;
                    else if (tick && dec_zero)            state_nx = ST_EXPIRED;
        default:    state_nx = state;
      endcase
    end
  end

  // Count, prescaler and expiry pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= START_BCD;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= tick && dec_zero;
      if (load) begin
        cnt_q <= cnt_ld;
        presc <= '0;
      end else begin
        if (tick) cnt_q <= cnt_dec;
        if ((state == ST_RUNNING) && !pause) presc <= at_term ? '0 : presc + 1'b1;
      end
    end
  end

  // Display scan
  logic [DW-1:0]              dwell;
  logic [IW-1:0]              idx, src_idx, dpos;
  logic [NUM_DIGITS-1:0][3:0] src_cnt;
  logic [NUM_DIGITS-1:0]      blank_d, an_nx;
  logic                       allz;
  logic [6:0]                 seg_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell <= '0;
      idx   <= '0;
    end else if (dwell == DMAX) begin
      dwell <= '0;
      idx   <= (idx == IMAX) ? '0 : idx + 1'b1;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  // During reset the display registers load the MS digit of START_BCD,
  // so steering the sources is all the reset handling they need.
  assign src_idx = reset ? '0 : idx;
  assign src_cnt = reset ? START_BCD : cnt_q;
  assign dpos    = IMAX - src_idx;

  // A digit blanks when it and everything above it are zero; digit 0 never.
  always_comb begin
    allz    = 1'b1;
    blank_d = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      allz       = allz && (src_cnt[d] == 4'd0);
      blank_d[d] = (LZ_BLANK != 0) && (d != 0) && allz;
    end
  end

  always_comb begin
    an_nx       = '1;
    an_nx[dpos] = 1'b0;
  end

  bcd_to_ssd u_seg (
    .bcd   (src_cnt[dpos]),
    .blank (blank_d[dpos]),
    .seg   (seg_nx)
  );

  always_ff @(posedge clk) begin
    anode  <= an_nx;
    ssdOut <= seg_nx;
  end

endmodule

// File: tb/tb_countdown_ssd_timer.sv
module tb_countdown_ssd_timer;
  localparam int N = 4, TD = 4, DWL = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, pause = 1'b0, load = 1'b0;
  logic [15:0] load_bcd = '0;
  logic [15:0] count_bcd;
  logic        running, expired;
  logic [3:0]  anode;
  logic [6:0]  ssdOut;

  always #5 clk = ~clk;

  countdown_ssd_timer #(
    .NUM_DIGITS(4), .TICK_DIV(4), .DWELL_CYCLES(3),
    .START_BCD(16'h0099), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .load_bcd(load_bcd), .count_bcd(count_bcd), .running(running),
    .expired(expired), .anode(anode), .ssdOut(ssdOut)
  );

  int checks = 0, errors = 0, exp_seen = 0;
  logic [6:0] segt [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100};

  // Reference model: decimal count value, state 0=idle 1=running 2=expired
  int         m_cnt, m_st, m_presc, m_t;
  bit         m_exp, m_valid = 1'b0;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [15:0] to_bcd(input int v);
    int x = v;
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clampv(input logic [15:0] b);
    int v = 0;
    int n;
    for (int i = 3; i >= 0; i--) begin
      n = int'(b[i*4 +: 4]);
      if (n > 9) n = 9;
      v = v * 10 + n;
    end
    return v;
  endfunction

  // Expected registered display for scan position idx showing value v.
  task automatic disp(input int idx, input int v);
    int p = 3 - idx;
    int pw = 1;
    for (int i = 0; i < p; i++) pw = pw * 10;
    m_an = 4'hF;
    m_an[p] = 1'b0;
    if (p != 0 && v < pw) m_seg = 7'h7F;
    else                  m_seg = segt[(v / pw) % 10];
  endtask

  task automatic model_update();
    if (reset) begin
      disp(0, 99);
      m_cnt = 99; m_st = 0; m_presc = 0; m_exp = 0; m_t = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      disp((m_t / DWL) % N, m_cnt);
      m_t++;
      m_exp = 0;
      if (load) begin
        m_cnt = clampv(load_bcd); m_st = 0; m_presc = 0;
      end else if (m_st == 0) begin
        if (start && !pause && m_cnt != 0) m_st = 1;
      end else if (m_st == 1) begin
        if (pause) m_st = 0;
        else if (m_presc == TD - 1) begin
          m_presc = 0;
          m_cnt--;
          if (m_cnt == 0) begin m_st = 2; m_exp = 1; end
        end else m_presc++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      chk("count_bcd", count_bcd, to_bcd(m_cnt));
      chk("running", {15'b0, running}, {15'b0, m_st == 1});
      chk("expired", {15'b0, expired}, {15'b0, m_exp});
      chk("anode", {12'b0, anode}, {12'b0, m_an});
      chk("ssdOut", {9'b0, ssdOut}, {9'b0, m_seg});
    end
    if (expired === 1'b1) exp_seen++;
  endtask

  task automatic cyc(input bit s, input bit p, input bit l, input logic [15:0] lv, input bit r);
    start = s; pause = p; load = l; load_bcd = lv; reset = r;
    @(posedge clk);
    model_update();
    #1;
    start = 1'b0; pause = 1'b0; load = 1'b0; reset = 1'b0;
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, load_bcd, 1'b0);
  endtask

  initial begin
    bit found;
    bit s, p, l, r;
    logic [15:0] lv;

    // 1: reset, full run from 0099 to expiry
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 1);
    chk("reset_count", count_bcd, 16'h0099);
    chk("reset_anode", {12'b0, anode}, 16'h0007);
    chk("reset_ssd_blank", {9'b0, ssdOut}, 16'h007F);
    exp_seen = 0;
    cyc(1, 0, 0, 16'h0, 0);
    idle(395);
    chk("pre_expiry_count", count_bcd, 16'h0001);
    idle(1);
    chk("expiry_pulse", {15'b0, expired}, 16'd1);
    chk("expiry_count", count_bcd, 16'h0000);
    idle(21);
    chk("expired_hold", count_bcd, 16'h0000);
    chk("expired_once", 16'(exp_seen), 16'd1);
    cyc(1, 0, 0, 16'h0, 0);
    chk("expired_start_ignored", {15'b0, running}, 16'd0);

    // 2: borrow across two digits
    cyc(0, 0, 1, 16'h0100, 0);
    cyc(1, 0, 0, 16'h0100, 0);
    idle(4);
    chk("borrow_0099", count_bcd, 16'h0099);
    idle(4);
    chk("borrow_0098", count_bcd, 16'h0098);

    // 3: clamp, pause and resume of a partial period
    cyc(0, 0, 1, 16'h0A5F, 0);
    chk("clamp_0959", count_bcd, 16'h0959);
    cyc(1, 0, 0, 16'h0, 0);
    idle(2);
    cyc(0, 1, 0, 16'h0, 0);
    idle(10);
    chk("paused_hold", count_bcd, 16'h0959);
    cyc(1, 0, 0, 16'h0, 0);
    idle(1);
    chk("resume_no_tick_yet", count_bcd, 16'h0959);
    idle(1);
    chk("resume_first_tick", count_bcd, 16'h0958);

    // 4: scan with leading-zero blanking
    cyc(0, 0, 1, 16'h0007, 0);
    idle(3);
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      if (anode == 4'b1110) found = 1'b1;
      else idle(1);
    end
    chk("scan_reach_ls", {15'b0, found}, 16'd1);
    chk("ls_digit_7", {9'b0, ssdOut}, {9'b0, 7'b0001111});
    idle(12);

    // 5: start at zero ignored; load+start+pause together
    cyc(0, 0, 1, 16'h0000, 0);
    exp_seen = 0;
    cyc(1, 0, 0, 16'h0000, 0);
    idle(6);
    chk("zero_start_idle", {15'b0, running}, 16'd0);
    chk("zero_no_expiry", 16'(exp_seen), 16'd0);
    cyc(1, 1, 1, 16'h0033, 0);
    chk("load_prio_count", count_bcd, 16'h0033);
    idle(3);
    chk("load_prio_idle", {15'b0, running}, 16'd0);

    // 6: reset mid-count
    cyc(0, 0, 1, 16'h0042, 0);
    cyc(1, 0, 0, 16'h0, 0);
    idle(5);
    chk("midcount_0041", count_bcd, 16'h0041);
    cyc(0, 0, 0, 16'h0, 1);
    chk("rst_count", count_bcd, 16'h0099);
    chk("rst_running", {15'b0, running}, 16'd0);
    chk("rst_expired", {15'b0, expired}, 16'd0);
    chk("rst_anode", {12'b0, anode}, 16'h0007);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 499) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 16'($urandom)
           : {8'h00, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      cyc(s, p, l, lv, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_ssd_timer.md
Name: countdown_ssd_timer

Overview:
- Parametrised BCD countdown timer with a built-in multiplexed N-digit seven-segment driver.
- Provides start, pause and load control, an expiry pulse, and optional leading-zero blanking.
- Sits beside the game-play controller. It drives the board's common-anode display and reports expiry to the game FSM.

Parameters:
- NUM_DIGITS, 4: digits displayed and counted (1..8).
- TICK_DIV, 100000000: clk cycles per count decrement (>=2).
- DWELL_CYCLES, 524288: clk cycles each digit stays lit per scan step (>=2).
- START_BCD, 16'h0099: reset value of the count, packed BCD with MS digit in the top nibble. Width is 4*NUM_DIGITS.
- LZ_BLANK, 1: 1 = blank leading zero digits (the LS digit is never blanked).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin or resume counting
- pause  in  1  one-cycle pulse: halt counting
- load  in  1  one-cycle pulse: capture load_bcd
- load_bcd  in  4*NUM_DIGITS  packed BCD load value
- count_bcd  out  4*NUM_DIGITS  current count (registered)
- running  out  1  high in RUNNING state
- expired  out  1  one-cycle pulse when the count reaches zero
- anode  out  NUM_DIGITS  active-low digit enables; bit NUM_DIGITS-1 is the leftmost (MS) digit
- ssdOut  out  7  active-low segments {a,b,c,d,e,f,g}, bit6=a, bit0=g

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values:
  - state=IDLE, count_bcd=START_BCD, prescaler=0.
  - Scan index=0, dwell counter=0.
  - expired=0, running=0.
  - anode=MS digit enabled (all others 1); ssdOut shows the decoded MS digit of START_BCD, blanked per LZ_BLANK.
- States:
  - IDLE: start and count!=0 -> RUNNING. Start with count==0 is ignored.
  - RUNNING: pause -> IDLE. Decrement tick taking count to 0 -> EXPIRED.
  - EXPIRED: start is ignored. Load -> IDLE.
  - Load from any state -> IDLE. Load has priority over start, pause and tick in the same cycle.
  - Start and pause in the same cycle: pause wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING. A tick is asserted in the cycle it equals TICK_DIV-1, then it wraps to 0.
  - Pause holds the prescaler value, so resume continues the partial period.
  - Load and reset clear the prescaler.
- Decrement: on a tick, count_bcd decrements as multi-digit BCD.
  - LS digit 0 becomes 9 and borrows into the next digit; the borrow ripples through all digits in the same cycle.
  - count_bcd updates one cycle after the tick.
- Expiry:
  - If the decrement produces all-zero, the state becomes EXPIRED in the same update.
  - expired pulses high for exactly that one cycle. The count holds at 0 and never wraps to 99..9.
- Load: any nibble of load_bcd greater than 9 is clamped to 9 on capture. count_bcd reflects the load the following cycle.
- Display scan:
  - The dwell counter counts 0..DWELL_CYCLES-1. On terminal count the scan index advances 0..NUM_DIGITS-1, then wraps to 0.
  - Non-power-of-two NUM_DIGITS is legal; the index never reaches NUM_DIGITS.
  - Index i enables anode bit NUM_DIGITS-1-i (low) and shows digit NUM_DIGITS-1-i of count_bcd, so index 0 is the MS digit.
  - Exactly one anode bit is low at any time. anode and ssdOut are registered, so they change together.
- Leading-zero blanking (LZ_BLANK=1): a digit is blanked (ssdOut=7'b1111111, anode still scanned) when it and all more-significant digits are 0. Digit 0 always displays.
- Segment codes 0-9:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
  - Any non-BCD value shows 1111111.
- Arithmetic: no divide or modulo operators; all digit handling uses BCD nibbles.
- Reset mid-count: returns to START_BCD/IDLE on the next edge. No expired pulse is generated.

Decomposition:
- Shared package timer_pkg: state encoding (IDLE, RUNNING, EXPIRED), SEG_BLANK constant, and segment constants for digits 0-9.
- Sub-module bcd_to_ssd: purely combinational, 4-bit BCD plus a blank flag -> 7-bit active-low segments. It is reused by other display blocks.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=4, DWELL_CYCLES=3, START_BCD=16'h0099, LZ_BLANK=1.
1. Reset, start, run 396 cycles -> count_bcd steps 0099 to 0000 every 4 cycles; expired high exactly one cycle; state EXPIRED; count holds 0000 for 20 more cycles.
2. Load 16'h0100, start, one tick -> count_bcd=0099 (borrow through two digits); after a second tick 0098.
3. Load 16'h0A5F -> count_bcd=16'h0959. Start then pause after 2 cycles, wait 10 cycles, start -> first tick 2 cycles after resume.
4. Scan with count 0007 -> anode cycles 0111,1011,1101,1110, each for 3 cycles. ssdOut=1111111 for the first three digits and 0001111 for the last.
5. Start asserted with count 0000 -> stays IDLE, no expired pulse. Load, start and pause asserted in the same cycle -> IDLE with the loaded value.
6. Reset asserted mid-count at 0042 -> next cycle count_bcd=0099, running=0, expired=0, scan index 0 (anode 0111).
